mp4_sram_2p_array: RTL and testbench
====================================

// Module: mp4_sram_2p_array
// PURPOSE
// - Parametrised successor to the single-port cache-array SRAM models: 1RW port (0) + 1R port (1).
// - Adds a per-lane write mask, a second read port, and a hardware clear sweep after reset.
// - Used for cache tag, valid and data arrays in the mp4 cache; port 1 serves lookup, port 0 serves fill/writeback.
// PARAMETERS
// - DATA_WIDTH   32  bits per word
// - ADDR_WIDTH   5   address bits; RAM_DEPTH = 1 << ADDR_WIDTH
// - WMASK_WIDTH  4   write-mask lanes; DATA_WIDTH % WMASK_WIDTH == 0, lane = DATA_WIDTH/WMASK_WIDTH bits
// - INIT_VALUE   0   word written to every entry by the clear sweep
// PORTS
// - clk0    in   1            clock
// - rst0    in   1            synchronous active-high reset
// - busy0   out  1            clear sweep in progress; all requests ignored while high
// - csb0    in   1            port 0 active-low chip select
// - web0    in   1            port 0 active-low write enable
// - wmask0  in   WMASK_WIDTH  port 0 lane write enable, active high
// - addr0   in   ADDR_WIDTH   port 0 address
// - din0    in   DATA_WIDTH   port 0 write data
// - dout0   out  DATA_WIDTH   port 0 read data
// - csb1    in   1            port 1 active-low chip select (read only)
// - addr1   in   ADDR_WIDTH   port 1 address
// - dout1   out  DATA_WIDTH   port 1 read data
// BEHAVIOUR
// - Inputs (csb*, web0, wmask0, addr*, din0) are registered at posedge clk0.
// - Array write and dout updates occur at the following negedge, so data is valid half a cycle after the sampling posedge.
// - FSM states: CLEAR, IDLE.
//   - rst0 sampled high at posedge -> CLEAR, clear pointer = 0, busy0 = 1, dout0 = dout1 = 0.
//   - CLEAR writes INIT_VALUE to mem[ptr] each cycle and increments ptr.
//   - After the write to RAM_DEPTH-1: -> IDLE, busy0 = 0. busy0 is high for exactly RAM_DEPTH cycles after reset deasserts.
//   - rst0 during CLEAR restarts the sweep from ptr 0.
//   - In CLEAR, csb0/csb1 are treated as 1: no user writes; dout0/dout1 hold 0.
// - Port 0 write (csb0 = 0, web0 = 0): for each lane i with wmask0[i] = 1, write mem[addr0] lane i from din0 lane i; other lanes keep their value.
//   - wmask0 = 0 is a legal no-op write.
//   - dout0 holds its previous value during a write cycle.
// - Port 0 read (csb0 = 0, web0 = 1): dout0 <= mem[addr0].
// - Port 1 read (csb1 = 0): dout1 <= mem[addr1].
// - Deselected port (csb = 1): its dout holds its last value indefinitely.
// - Collision, port 0 write and port 1 read to the same address in the same cycle:
//   - dout1 returns the OLD word (read-before-write), unless the optional feature below is compiled in.
//   - Different addresses are fully independent.
// - Both ports reading the same address is legal; both return the same word.
// - Addresses wrap naturally within ADDR_WIDTH; no out-of-range case exists.
// CONFIGURATION
// - MP4_SRAM_WR_FWD_EN defined:
//   - On a port 0 write / port 1 read collision, dout1 returns the merged NEW word (masked lanes from din0, other lanes from mem).
//   - Array contents are identical with or without the macro.
// - MP4_SRAM_WR_FWD_EN undefined: read-before-write as above; the forwarding mux is absent.
// TESTING
// - Reset + sweep, defaults:
//   - rst0 high 1 cycle -> busy0 high exactly 32 cycles, dout0 = dout1 = 0 throughout.
//   - Then every address reads 0 on both ports.
// - Masked write:
//   - Write 0xAABBCCDD, wmask0 = 4'b1111, addr 3; then write 0x11223344, wmask0 = 4'b0101, addr 3.
//   - Port 1 read of addr 3 -> 0xAA22CC44.
// - Collision, mem[7] = 0x0, same cycle write 0xDEADBEEF mask 4'b1111 to addr0 = 7 and read addr1 = 7:
//   - dout1 = 0x00000000 without MP4_SRAM_WR_FWD_EN, 0xDEADBEEF with it.
//   - Next-cycle read of addr 7 = 0xDEADBEEF in both builds.
// - Reset mid-sweep:
//   - rst0 at sweep cycle 10 -> busy0 stays high 32 more cycles.
//   - A write attempted while busy0 = 1 (addr 2, 0x55) has no effect; addr 2 reads 0 afterwards.
// - Hold on deselect:
//   - Read addr 3 on both ports, then csb0 = csb1 = 1 for 5 cycles while mem[3] is not rewritten.
//   - dout0/dout1 stay 0xAA22CC44.
// - Port 0 write hold:
//   - dout0 = 0xAA22CC44, then port 0 write to addr 9 -> dout0 unchanged that cycle.

Source files
------------

// File: rtl/mp4_sram_2p_array.sv
// mp4_sram_2p_array
//   Two-port cache-array SRAM model: port 0 is read/write with a per-lane
//   write mask (fill/writeback), port 1 is read-only (lookup). After reset a
//   hardware sweep writes INIT_VALUE to every entry; busy0 is high meanwhile
//   and all requests are dropped.
//
//   Timing: requests are registered at posedge clk0; the array write and the
//   dout registers update at the following negedge (data valid half a cycle
//   after the sampling edge).
//
//   Ports
//     clk0, rst0         clock, synchronous active-high reset
//     busy0              clear sweep in progress
//     csb0/web0/wmask0   port 0 select (low), write enable (low), lane mask (high)
//     addr0/din0/dout0   port 0 address, write data, read data
//     csb1/addr1/dout1   port 1 select (low), address, read data
//
//   Build option: MP4_SRAM_WR_FWD_EN -- on a same-address port 0 write /
//   port 1 read, dout1 returns the merged new word instead of the old one.
module mp4_sram_2p_array #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    WMASK_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk0,
  input  logic                   rst0,
  output logic                   busy0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE_W    = DATA_WIDTH / WMASK_WIDTH;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;

  logic                    csb0_r, web0_r, csb1_r;
  logic [WMASK_WIDTH-1:0]  wmask0_r;
  logic [ADDR_WIDTH-1:0]   addr0_r, addr1_r;
  logic [DATA_WIDTH-1:0]   din0_r;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   rd1_word;

  // FSM, request capture. Requests sampled while reset is asserted or the
  // sweep is still running are turned into deselects, so nothing presented
  // while busy0 is high ever reaches the array.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state <= CLEAR;
      ptr   <= '0;
      busy0 <= 1'b1;
    end else if (state == CLEAR) begin
      if (&ptr) begin
        state <= IDLE;
        busy0 <= 1'b0;
      end else begin
        ptr <= ptr + ADDR_WIDTH'(1);
      end
    end

    csb0_r   <= (rst0 || state == CLEAR) ? 1'b1 : csb0;
    csb1_r   <= (rst0 || state == CLEAR) ? 1'b1 : csb1;
    web0_r   <= web0;
    wmask0_r <= wmask0;
    addr0_r  <= addr0;
    addr1_r  <= addr1;
    din0_r   <= din0;
  end

  // Lane merge: masked lanes from din0, the rest from the stored word.
  for (genvar l = 0; l < WMASK_WIDTH; l++) begin : g_lane
    assign wr_word[l*LANE_W +: LANE_W] = wmask0_r[l] ? din0_r[l*LANE_W +: LANE_W]
                                                     : mem[addr0_r][l*LANE_W +: LANE_W];
  end

`ifdef MP4_SRAM_WR_FWD_EN
  logic collide;
  assign collide  = !csb0_r && !web0_r && (addr0_r == addr1_r);
  assign rd1_word = collide ? wr_word : mem[addr1_r];
`else
  // Nonblocking update below gives read-before-write on a collision.
  assign rd1_word = mem[addr1_r];
`endif

  // Array and output registers, half a cycle after the sampling edge.
  always_ff @(negedge clk0) begin
    if (state == CLEAR) begin
      mem[ptr] <= INIT_VALUE;
      dout0    <= '0;
      dout1    <= '0;
    end else begin
      if (!csb0_r) begin
        if (!web0_r) mem[addr0_r] <= wr_word;
        else         dout0        <= mem[addr0_r];
      end
      if (!csb1_r) dout1 <= rd1_word;
    end
  end

endmodule

// File: tb/tb_mp4_sram_2p_array.sv
module tb_mp4_sram_2p_array;

  logic        clk0 = 1'b0;
  logic        rst0, busy0, csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [4:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;

  int n_cmp = 0;
  int n_err = 0;

  mp4_sram_2p_array dut (
    .clk0(clk0), .rst0(rst0), .busy0(busy0),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: inputs driven now are sampled at the next posedge; return
  // just after the following negedge, when dout/busy0 reflect that sample.
  task automatic step();
    @(posedge clk0);
    @(negedge clk0);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = 4'h0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; csb1 = 1'b1;
  endtask

  task automatic rd(input logic en0, input logic [4:0] a0, input logic en1, input logic [4:0] a1);
    csb0 = !en0; web0 = 1'b1; addr0 = a0; csb1 = !en1; addr1 = a1; wmask0 = 4'h0;
  endtask

  // Count negedge samples with busy0 high, starting from the reset cycle.
  // Returns with one sample of busy0 low consumed. Bounded.
  task automatic count_busy(output int cnt, output logic nz);
    cnt = 1; nz = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (dout0 !== 32'h0 || dout1 !== 32'h0) nz = 1'b1;
      if (busy0 !== 1'b1) break;
      cnt++;
    end
  endtask

  int   cnt;
  logic nz;
  logic [31:0] exp_col;

  initial begin
    idle(); addr0 = '0; addr1 = '0; din0 = '0;

    // Reset + full sweep
    rst0 = 1'b1; step();
    chk("rst_busy", {31'b0, busy0}, 32'h1);
    chk("rst_dout0", dout0, 32'h0);
    chk("rst_dout1", dout1, 32'h0);
    rst0 = 1'b0;
    count_busy(cnt, nz);
    chk("sweep_len", 32'(cnt), 32'd32);
    chk("sweep_dout_zero", {31'b0, nz}, 32'h0);

    for (int a = 0; a < 32; a++) begin
      rd(1'b1, 5'(a), 1'b1, 5'(a)); step();
      chk($sformatf("clr0_%0d", a), dout0, 32'h0);
      chk($sformatf("clr1_%0d", a), dout1, 32'h0);
    end

    // Masked write
    wr0(5'd3, 32'hAABBCCDD, 4'b1111); step();
    wr0(5'd3, 32'h11223344, 4'b0101); step();
    rd(1'b0, 5'd0, 1'b1, 5'd3); step();
    chk("mask_p1", dout1, 32'hAA22CC44);

    // Hold on deselect
    rd(1'b1, 5'd3, 1'b1, 5'd3); step();
    chk("both_rd_p0", dout0, 32'hAA22CC44);
    chk("both_rd_p1", dout1, 32'hAA22CC44);
    idle();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold0_%0d", i), dout0, 32'hAA22CC44);
      chk($sformatf("hold1_%0d", i), dout1, 32'hAA22CC44);
    end

    // Port 0 write leaves dout0 unchanged
    wr0(5'd9, 32'h12345678, 4'b1111); step();
    chk("wr_hold_p0", dout0, 32'hAA22CC44);
    rd(1'b1, 5'd9, 1'b0, 5'd0); step();
    chk("rd9_p0", dout0, 32'h12345678);

    // Zero-mask write is a no-op
    wr0(5'd9, 32'hFFFFFFFF, 4'b0000); step();
    rd(1'b0, 5'd0, 1'b1, 5'd9); step();
    chk("nomask_p1", dout1, 32'h12345678);

    // Collision on addr 7 (still the cleared value)
    wr0(5'd7, 32'hDEADBEEF, 4'b1111); csb1 = 1'b0; addr1 = 5'd7; step();
`ifdef MP4_SRAM_WR_FWD_EN
    exp_col = 32'hDEADBEEF;
`else
    exp_col = 32'h00000000;
`endif
    chk("collide_p1", dout1, exp_col);
    rd(1'b1, 5'd7, 1'b1, 5'd7); step();
    chk("after_col_p0", dout0, 32'hDEADBEEF);
    chk("after_col_p1", dout1, 32'hDEADBEEF);

    // Different addresses in the same cycle are independent
    wr0(5'd4, 32'hCAFEF00D, 4'b1111); csb1 = 1'b0; addr1 = 5'd3; step();
    chk("indep_p1", dout1, 32'hAA22CC44);

    // Reset mid-sweep, write attempted while busy
    rst0 = 1'b1; idle(); step();
    rst0 = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst0 = 1'b1; step();
    rst0 = 1'b0;
    wr0(5'd2, 32'h00000055, 4'b1111);
    count_busy(cnt, nz);
    idle();
    chk("resweep_len", 32'(cnt), 32'd32);
    chk("resweep_dout_zero", {31'b0, nz}, 32'h0);
    rd(1'b1, 5'd2, 1'b1, 5'd2); step();
    chk("busy_wr_p0", dout0, 32'h0);
    chk("busy_wr_p1", dout1, 32'h0);
    rd(1'b1, 5'd3, 1'b1, 5'd7); step();
    chk("recleared3", dout0, 32'h0);
    chk("recleared7", dout1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
